// File: rtl/rib_arb_pkg.sv
// Shared definitions for the RIB two-master arbiter: FSM encoding, master
// indices and the fixed-priority pick.
package rib_arb_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

    // LSU beats IFU whenever it requests.
    function automatic logic fixed_pick(input logic [1:0] req);
        return req[M_LSU] ? M_LSU : M_IFU;
    endfunction

endpackage

// File: rtl/rib_arb_sel.sv
// Winner selection for rib_arb. Holds a stalled winner until it is granted or
// drops its request. Round-robin arbitration (with its last-granted pointer)
// is built only when RIB_ARB_RR_EN is defined; otherwise LSU has fixed priority.
module rib_arb_sel
    import rib_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       arb_en_i,
    input  logic [1:0] req_i,
    input  logic       s_gnt_i,
    output logic       winner_o,
    output logic       any_o,
    output logic       grant_o
);

    logic hold_vld_q, hold_vld_d;
    logic hold_idx_q, hold_idx_d;
    logic pick;

`ifdef RIB_ARB_RR_EN
    logic ptr_q, ptr_d;

    // When both request, the master not granted last time wins.
    always_comb begin
        pick = fixed_pick(req_i);
        if (req_i == 2'b11) begin
            pick = ~ptr_q;
        end
    end

    // Pointer follows the granted master only on an actual grant.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_o) begin
            ptr_d = winner_o;
        end
    end

    // Last-granted pointer register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= M_IFU;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign pick = fixed_pick(req_i);
`endif

    assign any_o    = |req_i;
    assign winner_o = (hold_vld_q && req_i[hold_idx_q]) ? hold_idx_q : pick;
    assign grant_o  = arb_en_i & any_o & s_gnt_i;

    // A request left waiting on the slave pins the winner for the next cycle.
    always_comb begin
        hold_vld_d = arb_en_i & any_o & ~s_gnt_i;
        hold_idx_d = winner_o;
    end

    // Stalled-winner register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_vld_q <= 1'b0;
            hold_idx_q <= M_IFU;
        end else begin
            hold_vld_q <= hold_vld_d;
            hold_idx_q <= hold_idx_d;
        end
    end

endmodule

// File: rtl/rib_arb.sv
// RIB arbiter: two masters (IFU=m0, LSU=m1) share one slave, one outstanding
// transaction at a time. A BUSY transaction that sees no slave response for
// RSP_TIMEOUT cycles is aborted with an error response to the owner.
// Optional macro RIB_ARB_RR_EN selects round-robin instead of fixed priority.
module rib_arb
    import rib_arb_pkg::*;
#(
    parameter int unsigned RSP_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic [31:0] i_m0_addr,
    input  logic        i_m0_wrcs,
    input  logic [3:0]  i_m0_mask,
    input  logic [31:0] i_m0_wdata,
    input  logic        i_m0_req,
    input  logic        i_m0_rdy,
    output logic        o_m0_gnt,
    output logic        o_m0_rsp,
    output logic        o_m0_rsp_err,
    output logic [31:0] o_m0_rdata,

    input  logic [31:0] i_m1_addr,
    input  logic        i_m1_wrcs,
    input  logic [3:0]  i_m1_mask,
    input  logic [31:0] i_m1_wdata,
    input  logic        i_m1_req,
    input  logic        i_m1_rdy,
    output logic        o_m1_gnt,
    output logic        o_m1_rsp,
    output logic        o_m1_rsp_err,
    output logic [31:0] o_m1_rdata,

    output logic [31:0] o_s_addr,
    output logic        o_s_wrcs,
    output logic [3:0]  o_s_mask,
    output logic [31:0] o_s_wdata,
    output logic        o_s_req,
    output logic        o_s_rdy,
    input  logic [31:0] i_s_rdata,
    input  logic        i_s_gnt,
    input  logic        i_s_rsp
);

    // At least one bit so RSP_TIMEOUT=0 still elaborates.
    localparam int unsigned    CntW   = (RSP_TIMEOUT < 1) ? 1 : $clog2(RSP_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};
    localparam logic [CntW-1:0] CntTmo = CntW'(RSP_TIMEOUT);

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic winner, any_req, grant, arb_en;
    logic own_rdy, done, tmo;

    assign arb_en  = (state_q == StIdle) && !i_rst;
    assign own_rdy = (owner_q == M_LSU) ? i_m1_rdy : i_m0_rdy;
    assign done    = (state_q == StBusy) && i_s_rsp && own_rdy;
    // Completion wins over a coincident timeout.
    assign tmo     = (state_q == StBusy) && !done && (cnt_q == CntTmo);

    rib_arb_sel u_sel (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .arb_en_i (arb_en),
        .req_i    ({i_m1_req, i_m0_req}),
        .s_gnt_i  (i_s_gnt),
        .winner_o (winner),
        .any_o    (any_req),
        .grant_o  (grant)
    );

    // Next state: grant enters BUSY, completion or timeout returns to IDLE.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StBusy;
                    owner_d = winner;
                    cnt_d   = '0;
                end
            end
            StBusy: begin
                if (done || tmo) begin
                    state_d = StIdle;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, owner and timeout counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            owner_q <= M_IFU;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output steering; everything is forced low while reset is asserted.
    always_comb begin
        o_m0_gnt     = 1'b0;
        o_m0_rsp     = 1'b0;
        o_m0_rsp_err = 1'b0;
        o_m0_rdata   = '0;
        o_m1_gnt     = 1'b0;
        o_m1_rsp     = 1'b0;
        o_m1_rsp_err = 1'b0;
        o_m1_rdata   = '0;
        o_s_addr     = '0;
        o_s_wrcs     = 1'b0;
        o_s_mask     = '0;
        o_s_wdata    = '0;
        o_s_req      = 1'b0;
        o_s_rdy      = 1'b0;
        if (!i_rst) begin
            if (state_q == StIdle) begin
                if (any_req) begin
                    o_s_req   = 1'b1;
                    o_s_addr  = (winner == M_LSU) ? i_m1_addr  : i_m0_addr;
                    o_s_wrcs  = (winner == M_LSU) ? i_m1_wrcs  : i_m0_wrcs;
                    o_s_mask  = (winner == M_LSU) ? i_m1_mask  : i_m0_mask;
                    o_s_wdata = (winner == M_LSU) ? i_m1_wdata : i_m0_wdata;
                    o_m0_gnt  = grant && (winner == M_IFU);
                    o_m1_gnt  = grant && (winner == M_LSU);
                end
            end else begin
                o_s_rdy = own_rdy;
                if (owner_q == M_LSU) begin
                    o_m1_rsp     = i_s_rsp | tmo;
                    o_m1_rsp_err = tmo;
                    o_m1_rdata   = tmo ? '0 : i_s_rdata;
                end else begin
                    o_m0_rsp     = i_s_rsp | tmo;
                    o_m0_rsp_err = tmo;
                    o_m0_rdata   = tmo ? '0 : i_s_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_rib_arb.sv
// Self-checking bench for rib_arb (RSP_TIMEOUT=4). Directed scenarios plus a
// randomized run compared against a transaction-level reference model.
// Honours RIB_ARB_RR_EN the same way as the design.
module tb_rib_arb;

    localparam int unsigned TMO = 4;

    logic        i_clk, i_rst;
    logic [31:0] i_m0_addr, i_m0_wdata, i_m1_addr, i_m1_wdata, i_s_rdata;
    logic [3:0]  i_m0_mask, i_m1_mask;
    logic        i_m0_wrcs, i_m0_req, i_m0_rdy, i_m1_wrcs, i_m1_req, i_m1_rdy;
    logic        i_s_gnt, i_s_rsp;
    logic        o_m0_gnt, o_m0_rsp, o_m0_rsp_err, o_m1_gnt, o_m1_rsp, o_m1_rsp_err;
    logic [31:0] o_m0_rdata, o_m1_rdata, o_s_addr, o_s_wdata;
    logic [3:0]  o_s_mask;
    logic        o_s_wrcs, o_s_req, o_s_rdy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: transaction view of the arbiter.
    bit m_busy = 0, m_owner = 0, m_wait_vld = 0, m_wait = 0;
    int m_age = 0;  // 1-based count of BUSY cycles for the current owner
`ifdef RIB_ARB_RR_EN
    bit m_last = 0;
`endif
    logic [140:0] exp_v;

    rib_arb #(.RSP_TIMEOUT(TMO)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_m0_addr    (i_m0_addr),
        .i_m0_wrcs    (i_m0_wrcs),
        .i_m0_mask    (i_m0_mask),
        .i_m0_wdata   (i_m0_wdata),
        .i_m0_req     (i_m0_req),
        .i_m0_rdy     (i_m0_rdy),
        .o_m0_gnt     (o_m0_gnt),
        .o_m0_rsp     (o_m0_rsp),
        .o_m0_rsp_err (o_m0_rsp_err),
        .o_m0_rdata   (o_m0_rdata),
        .i_m1_addr    (i_m1_addr),
        .i_m1_wrcs    (i_m1_wrcs),
        .i_m1_mask    (i_m1_mask),
        .i_m1_wdata   (i_m1_wdata),
        .i_m1_req     (i_m1_req),
        .i_m1_rdy     (i_m1_rdy),
        .o_m1_gnt     (o_m1_gnt),
        .o_m1_rsp     (o_m1_rsp),
        .o_m1_rsp_err (o_m1_rsp_err),
        .o_m1_rdata   (o_m1_rdata),
        .o_s_addr     (o_s_addr),
        .o_s_wrcs     (o_s_wrcs),
        .o_s_mask     (o_s_mask),
        .o_s_wdata    (o_s_wdata),
        .o_s_req      (o_s_req),
        .o_s_rdy      (o_s_rdy),
        .i_s_rdata    (i_s_rdata),
        .i_s_gnt      (i_s_gnt),
        .i_s_rsp      (i_s_rsp)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic logic [140:0] obs_vec();
        return {o_m0_gnt, o_m0_rsp, o_m0_rsp_err, o_m0_rdata,
                o_m1_gnt, o_m1_rsp, o_m1_rsp_err, o_m1_rdata,
                o_s_addr, o_s_wrcs, o_s_mask, o_s_wdata, o_s_req, o_s_rdy};
    endfunction

    function automatic logic pick_winner(input logic [1:0] req);
        if (m_wait_vld && req[m_wait]) return m_wait;
        if (req == 2'b11) begin
`ifdef RIB_ARB_RR_EN
            return !m_last;
`else
            return 1'b1;
`endif
        end
        return req[1];
    endfunction

    function automatic logic [140:0] model_out();
        logic        g0 = 0, r0 = 0, e0 = 0, g1 = 0, r1 = 0, e1 = 0;
        logic        swr = 0, sreq = 0, srdy = 0;
        logic [31:0] d0 = 0, d1 = 0, sa = 0, sw = 0, rd;
        logic [3:0]  sm = 0;
        logic [1:0]  req;
        logic        w, rdy, fin, tmo, rsp;
        req = {i_m1_req, i_m0_req};
        if (!i_rst) begin
            if (!m_busy) begin
                if (req != 2'b00) begin
                    w    = pick_winner(req);
                    sreq = 1'b1;
                    sa   = w ? i_m1_addr  : i_m0_addr;
                    swr  = w ? i_m1_wrcs  : i_m0_wrcs;
                    sm   = w ? i_m1_mask  : i_m0_mask;
                    sw   = w ? i_m1_wdata : i_m0_wdata;
                    if (i_s_gnt) begin
                        if (w) g1 = 1'b1; else g0 = 1'b1;
                    end
                end
            end else begin
                rdy  = m_owner ? i_m1_rdy : i_m0_rdy;
                srdy = rdy;
                fin  = i_s_rsp && rdy;
                tmo  = !fin && (m_age == TMO + 1);
                rsp  = i_s_rsp || tmo;
                rd   = tmo ? 32'h0 : i_s_rdata;
                if (m_owner) begin
                    r1 = rsp; e1 = tmo; d1 = rd;
                end else begin
                    r0 = rsp; e0 = tmo; d0 = rd;
                end
            end
        end
        return {g0, r0, e0, d0, g1, r1, e1, d1, sa, swr, sm, sw, sreq, srdy};
    endfunction

    task automatic model_advance();
        logic [1:0] req;
        logic       w, rdy;
        req = {i_m1_req, i_m0_req};
        if (i_rst) begin
            m_busy = 0; m_owner = 0; m_wait_vld = 0; m_age = 0;
`ifdef RIB_ARB_RR_EN
            m_last = 0;
`endif
        end else if (!m_busy) begin
            if (req != 2'b00) begin
                w = pick_winner(req);
                if (i_s_gnt) begin
                    m_busy = 1; m_owner = w; m_age = 1; m_wait_vld = 0;
`ifdef RIB_ARB_RR_EN
                    m_last = w;
`endif
                end else begin
                    m_wait_vld = 1; m_wait = w;
                end
            end else begin
                m_wait_vld = 0;
            end
        end else begin
            rdy = m_owner ? i_m1_rdy : i_m0_rdy;
            if ((i_s_rsp && rdy) || m_age == TMO + 1) m_busy = 0;
            else m_age++;
        end
    endtask

    task automatic settle();
        @(negedge i_clk);
        exp_v = model_out();
    endtask

    task automatic commit();
        @(posedge i_clk);
        model_advance();
        #1;
    endtask

    task automatic idle_inputs();
        i_m0_req = 0; i_m1_req = 0; i_m0_rdy = 0; i_m1_rdy = 0;
        i_s_gnt = 0; i_s_rsp = 0; i_s_rdata = 0;
        i_m0_addr = $urandom; i_m0_wdata = $urandom; i_m0_mask = 4'($urandom);
        i_m1_addr = $urandom; i_m1_wdata = $urandom; i_m1_mask = 4'($urandom);
        i_m0_wrcs = 1'($urandom); i_m1_wrcs = 1'($urandom);
    endtask

    task automatic test_reset();
        idle_inputs();
        i_rst = 1; i_m0_req = 1; i_m1_req = 1; i_s_gnt = 1; i_s_rsp = 1;
        i_m0_rdy = 1; i_m1_rdy = 1; i_s_rdata = $urandom;
        settle();
        n_vec++;
        if (obs_vec() !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 0", obs_vec());
        end
        commit();
        settle();
        n_vec++;
        if ({o_s_req, o_s_rdy, o_m0_gnt, o_m1_gnt} !== 4'b0) begin
            n_err++; $display("FAIL reset_held: got %b expected 0000",
                              {o_s_req, o_s_rdy, o_m0_gnt, o_m1_gnt});
        end
        commit();
        i_rst = 0;
        idle_inputs();
    endtask

    task automatic test_fixed_prio();
        i_m0_addr = 32'h1000_0000; i_m1_addr = 32'h2000_0000;
        i_m0_req = 1; i_m1_req = 1; i_s_gnt = 1;
        settle();
        n_vec++;
        if ({o_m1_gnt, o_m0_gnt, o_s_req} !== 3'b101) begin
            n_err++; $display("FAIL prio_gnt: got %b expected 101", {o_m1_gnt, o_m0_gnt, o_s_req});
        end
        n_vec++;
        if ({o_s_addr, o_s_wdata, o_s_mask} !== {32'h2000_0000, i_m1_wdata, i_m1_mask}) begin
            n_err++; $display("FAIL prio_payload: got %h/%h expected 20000000/%h",
                              o_s_addr, o_s_wdata, i_m1_wdata);
        end
        commit();
        i_m0_req = 0; i_m1_req = 0; i_s_gnt = 0; i_s_rsp = 1; i_m1_rdy = 1;
        i_s_rdata = $urandom;
        settle();
        n_vec++;
        if ({o_s_req, o_m1_rsp, o_m1_rdata, o_m0_rsp, o_m0_rdata} !==
            {1'b0, 1'b1, i_s_rdata, 1'b0, 32'h0}) begin
            n_err++; $display("FAIL prio_rsp: got m1 %b/%h m0 %b/%h expected m1 1/%h m0 0/0",
                              o_m1_rsp, o_m1_rdata, o_m0_rsp, o_m0_rdata, i_s_rdata);
        end
        commit();
        idle_inputs();
    endtask

    task automatic test_alternate();
        logic [1:0] exp_g;
        i_rst = 1;
        settle();
        commit();
        i_rst = 0;
        i_m0_req = 1; i_m1_req = 1; i_s_gnt = 1; i_s_rsp = 1; i_m0_rdy = 1; i_m1_rdy = 1;
        for (int i = 0; i < 8; i++) begin
            i_s_rdata = $urandom;
            settle();
            if (i % 2 == 0) begin
`ifdef RIB_ARB_RR_EN
                exp_g = ((i / 2) % 2 == 0) ? 2'b10 : 2'b01;
`else
                exp_g = 2'b10;
`endif
                n_vec++;
                if ({o_m1_gnt, o_m0_gnt} !== exp_g) begin
                    n_err++; $display("FAIL alt_grant%0d: got %b expected %b",
                                      i / 2, {o_m1_gnt, o_m0_gnt}, exp_g);
                end
            end
            n_vec++;
            if (obs_vec() !== exp_v) begin
                n_err++; $display("FAIL alt_model: got %h expected %h", obs_vec(), exp_v);
            end
            commit();
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        i_m0_req = 1; i_s_gnt = 1;
        settle();
        n_vec++;
        if ({o_m1_gnt, o_m0_gnt} !== 2'b01) begin
            n_err++; $display("FAIL bp_grant: got %b expected 01", {o_m1_gnt, o_m0_gnt});
        end
        commit();
        i_m0_req = 0; i_m1_req = 1; i_m0_rdy = 0; i_s_rsp = 1; i_s_rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            settle();
            n_vec++;
            if ({o_s_req, o_m1_gnt, o_m1_rsp, o_s_rdy} !== 4'b0) begin
                n_err++; $display("FAIL bp_hold%0d: got %b expected 0000",
                                  k, {o_s_req, o_m1_gnt, o_m1_rsp, o_s_rdy});
            end
            commit();
        end
        i_m0_rdy = 1;
        settle();
        n_vec++;
        if ({o_m0_rsp, o_m0_rsp_err, o_m0_rdata, o_m1_rsp, o_s_rdy} !==
            {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL bp_deliver: got rsp %b err %b data %h m1 %b expected 1 0 deadbeef 0",
                              o_m0_rsp, o_m0_rsp_err, o_m0_rdata, o_m1_rsp);
        end
        commit();
        i_s_rsp = 0;
        settle();
        n_vec++;
        if ({o_m1_gnt, o_m1_rsp} !== 2'b10) begin
            n_err++; $display("FAIL bp_next_grant: got %b expected 10", {o_m1_gnt, o_m1_rsp});
        end
        commit();
        i_m1_req = 0; i_s_rsp = 1; i_m1_rdy = 1;
        settle();
        commit();
        idle_inputs();
    endtask

    task automatic test_timeout();
        i_m1_req = 1; i_s_gnt = 1;
        settle();
        commit();
        i_m1_req = 0; i_s_gnt = 0; i_m1_rdy = 0; i_s_rdata = 32'h1234_5678;
        for (int k = 1; k <= 5; k++) begin
            settle();
            n_vec++;
            if (k < 5) begin
                if ({o_m1_rsp, o_m1_rsp_err, o_m1_rdata, o_m0_rsp} !==
                    {2'b00, 32'h1234_5678, 1'b0}) begin
                    n_err++; $display("FAIL tmo_wait%0d: got rsp %b err %b data %h expected 0 0 12345678",
                                      k, o_m1_rsp, o_m1_rsp_err, o_m1_rdata);
                end
            end else begin
                if ({o_m1_rsp, o_m1_rsp_err, o_m1_rdata, o_m0_rsp} !== {2'b11, 32'h0, 1'b0}) begin
                    n_err++; $display("FAIL tmo_fire: got rsp %b err %b data %h expected 1 1 0",
                                      o_m1_rsp, o_m1_rsp_err, o_m1_rdata);
                end
            end
            commit();
        end
        i_m0_req = 1;
        settle();
        n_vec++;
        if ({o_s_req, o_s_addr, o_m1_rsp} !== {1'b1, i_m0_addr, 1'b0}) begin
            n_err++; $display("FAIL tmo_idle: got req %b addr %h expected 1 %h",
                              o_s_req, o_s_addr, i_m0_addr);
        end
        commit();
        idle_inputs();
        settle();
        commit();
    endtask

    task automatic test_rst_busy();
        i_m0_req = 1; i_s_gnt = 1;
        settle();
        commit();
        i_m0_req = 0; i_s_gnt = 0;
        settle();
        commit();
        i_rst = 1; i_s_rsp = 1; i_m0_rdy = 1; i_s_rdata = $urandom;
        settle();
        n_vec++;
        if (obs_vec() !== '0) begin
            n_err++; $display("FAIL rstbusy_during: got %h expected 0", obs_vec());
        end
        commit();
        i_rst = 0;
        settle();
        n_vec++;
        if (obs_vec() !== '0) begin
            n_err++; $display("FAIL rstbusy_after: got %h expected 0", obs_vec());
        end
        commit();
        i_s_rsp = 0; i_m1_req = 1; i_s_gnt = 1;
        settle();
        n_vec++;
        if ({o_m1_gnt, o_s_req, o_m0_gnt} !== 3'b110) begin
            n_err++; $display("FAIL rstbusy_regrant: got %b expected 110",
                              {o_m1_gnt, o_s_req, o_m0_gnt});
        end
        commit();
        i_m1_req = 0; i_s_rsp = 1; i_m1_rdy = 1;
        settle();
        commit();
        idle_inputs();
    endtask

    task automatic test_gnt_stall();
        i_m0_req = 1; i_s_gnt = 0;
        for (int k = 0; k < 7; k++) begin
            if (k == 5) i_m1_req = 1;
            settle();
            n_vec++;
            if ({o_s_req, o_m0_gnt, o_m1_gnt, o_s_addr} !== {3'b100, i_m0_addr}) begin
                n_err++; $display("FAIL stall%0d: got req %b addr %h expected 1 %h",
                                  k, o_s_req, o_s_addr, i_m0_addr);
            end
            commit();
        end
        i_s_gnt = 1;
        settle();
        n_vec++;
        if ({o_m1_gnt, o_m0_gnt, o_s_addr} !== {2'b01, i_m0_addr}) begin
            n_err++; $display("FAIL stall_grant: got %b addr %h expected 01 %h",
                              {o_m1_gnt, o_m0_gnt}, o_s_addr, i_m0_addr);
        end
        commit();
        i_m0_req = 0; i_m1_req = 0; i_s_gnt = 0; i_s_rsp = 1; i_m0_rdy = 1;
        settle();
        commit();
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            i_rst = ($urandom_range(0, 63) == 0);
            i_m0_req = 1'($urandom); i_m1_req = 1'($urandom);
            i_m0_rdy = ($urandom_range(0, 2) != 0); i_m1_rdy = ($urandom_range(0, 2) != 0);
            i_s_gnt = 1'($urandom); i_s_rsp = ($urandom_range(0, 2) == 0);
            i_s_rdata = $urandom;
            i_m0_addr = $urandom; i_m0_wdata = $urandom; i_m0_mask = 4'($urandom);
            i_m1_addr = $urandom; i_m1_wdata = $urandom; i_m1_mask = 4'($urandom);
            i_m0_wrcs = 1'($urandom); i_m1_wrcs = 1'($urandom);
            settle();
            n_vec++;
            if (obs_vec() !== exp_v) begin
                n_err++; $display("FAIL random%0d: got %h expected %h", c, obs_vec(), exp_v);
            end
            commit();
        end
        i_rst = 0;
        idle_inputs();
    endtask

    initial begin
        i_rst = 1;
        idle_inputs();
        test_reset();
        test_fixed_prio();
        test_alternate();
        test_backpressure();
        test_timeout();
        test_rst_busy();
        test_gnt_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
